// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: writeback result-source encodings and
// load funct3 codes used by the writeback stage and its load extractor.
package riscv_pkg;

  // Writeback result source. 2'b11 is reserved and selects the ALU result.
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // Load width / sign encodings (funct3 of the LOAD opcode).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_load_extract.sv
// load_extract: combinational sub-word load alignment and extension.
// Ports:
//   funct3     in  3   load width/sign (lb, lh, lw, lbu, lhu; others act as lw)
//   off        in  2   byte offset within the word (address bits [1:0])
//   word       in  32  raw aligned data-memory word
//   data       out 32  aligned, sign- or zero-extended load value
//   misaligned out 1   access is not naturally aligned for its width
module load_extract
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = '0;
    case (off)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
  end

  assign w_half = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{w_byte[7]}}, w_byte};
      F3_LBU: data = {24'd0, w_byte};
      F3_LH: begin
        data       = {{16{w_half[15]}}, w_half};
        misaligned = off[0];
      end
      F3_LHU: begin
        data       = {16'd0, w_half};
        misaligned = off[0];
      end
      default: begin
        // lw and any undefined encoding: full word
        data       = word;
        misaligned = |off;
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register and register-file write driver.
// Captures the MEM-stage bundle, selects ALU / load / PC+4 result, aligns
// sub-word loads, flags misaligned loads and counts retired instructions.
// Ports:
//   clk, reset (async active-low)
//   valid_m, regwrite_m, result_src_m, funct3_m, rd_m,
//   alu_result_m, read_data_m, pc_plus_4_m     MEM-stage bundle
//   stall_w, flush_w                           WB register hold / bubble
//   writeback_control, rd, writeback_data      register-file write port
//   misaligned_load                            WB holds a misaligned load
//   instret                                    retired-instruction counter
// All outputs depend only on WB state.
module writeback_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_m,
  input  logic             regwrite_m,
  input  logic [1:0]       result_src_m,
  input  logic [2:0]       funct3_m,
  input  logic [4:0]       rd_m,
  input  logic [XLEN-1:0]  alu_result_m,
  input  logic [XLEN-1:0]  read_data_m,
  input  logic [XLEN-1:0]  pc_plus_4_m,
  input  logic             stall_w,
  input  logic             flush_w,
  output logic             writeback_control,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  writeback_data,
  output logic             misaligned_load,
  output logic [CNT_W-1:0] instret
);

  import riscv_pkg::*;

  logic             r_valid_w;
  logic             r_regwrite_w;
  logic [1:0]       r_result_src_w;
  logic [2:0]       r_funct3_w;
  logic [4:0]       r_rd_w;
  logic [XLEN-1:0]  r_alu_result_w;
  logic [XLEN-1:0]  r_read_data_w;
  logic [XLEN-1:0]  r_pc_plus_4_w;
  logic [CNT_W-1:0] r_instret;

  logic [XLEN-1:0]  w_load_data;
  logic             w_load_misaligned;
  logic             w_is_load;
  logic             w_retire;

  load_extract u_load_extract (
    .funct3     (r_funct3_w),
    .off        (r_alu_result_w[1:0]),
    .word       (r_read_data_w),
    .data       (w_load_data),
    .misaligned (w_load_misaligned)
  );

  assign w_is_load = (r_result_src_w == RES_MEM);

  // The resident instruction leaves WB whenever the register advances;
  // a flush overrides a stall, so it retires even when both are high.
  assign w_retire = r_valid_w & (flush_w | ~stall_w) & ~misaligned_load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid_w      <= '0;
      r_regwrite_w   <= '0;
      r_result_src_w <= '0;
      r_funct3_w     <= '0;
      r_rd_w         <= '0;
      r_alu_result_w <= '0;
      r_read_data_w  <= '0;
      r_pc_plus_4_w  <= '0;
      r_instret      <= '0;
    end else begin
      if (flush_w) begin
        r_valid_w    <= 1'b0;
        r_regwrite_w <= 1'b0;
      end else if (!stall_w) begin
        r_valid_w      <= valid_m;
        r_regwrite_w   <= regwrite_m;
        r_result_src_w <= result_src_m;
        r_funct3_w     <= funct3_m;
        r_rd_w         <= rd_m;
        r_alu_result_w <= alu_result_m;
        r_read_data_w  <= read_data_m;
        r_pc_plus_4_w  <= pc_plus_4_m;
      end
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  always_comb begin
    writeback_data = r_alu_result_w;
    case (r_result_src_w)
      RES_MEM: writeback_data = w_load_data;
      RES_PC4: writeback_data = r_pc_plus_4_w;
      default: writeback_data = r_alu_result_w;
    endcase
  end

  assign misaligned_load   = r_valid_w & w_is_load & w_load_misaligned;
  assign writeback_control = r_valid_w & r_regwrite_w & (r_rd_w != 5'd0)
                           & ~misaligned_load;
  assign rd                = r_rd_w;
  assign instret           = r_instret;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        valid_m;
  logic        regwrite_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m;
  logic [31:0] read_data_m;
  logic [31:0] pc_plus_4_m;
  logic        stall_w;
  logic        flush_w;
  logic        writeback_control;
  logic [4:0]  rd;
  logic [31:0] writeback_data;
  logic        misaligned_load;
  logic [63:0] instret;

  writeback_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .valid_m           (valid_m),
    .regwrite_m        (regwrite_m),
    .result_src_m      (result_src_m),
    .funct3_m          (funct3_m),
    .rd_m              (rd_m),
    .alu_result_m      (alu_result_m),
    .read_data_m       (read_data_m),
    .pc_plus_4_m       (pc_plus_4_m),
    .stall_w           (stall_w),
    .flush_w           (flush_w),
    .writeback_control (writeback_control),
    .rd                (rd),
    .writeback_data    (writeback_data),
    .misaligned_load   (misaligned_load),
    .instret           (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ckdat;
    logic        wc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic [63:0] cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // instret reference: retires the resident instruction when WB advances
  logic [63:0] m_cnt  = '0;
  logic        m_pend = 1'b0;

  localparam logic [31:0] W = 32'h80FF7F01;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic rw, input logic [1:0] src,
                      input logic [2:0] f3, input logic [4:0] rdi,
                      input logic [31:0] alu, input logic [31:0] rdat,
                      input logic [31:0] pc4, input logic st, input logic fl,
                      input logic ckdat, input logic ewc, input logic [4:0] erd,
                      input logic [31:0] edata, input logic emis,
                      input logic eret, input string name);
    exp_t e;
    @(negedge clk);
    valid_m = v; regwrite_m = rw; result_src_m = src; funct3_m = f3;
    rd_m = rdi; alu_result_m = alu; read_data_m = rdat; pc_plus_4_m = pc4;
    stall_w = st; flush_w = fl;
    if (m_pend && (fl || !st)) m_cnt = m_cnt + 64'd1;
    if (fl) m_pend = 1'b0;
    else if (!st) m_pend = eret;
    e.ckdat = ckdat; e.wc = ewc; e.rd = erd; e.data = edata; e.mis = emis;
    e.cnt = m_cnt; e.name = name;
    q.push_back(e);
  endtask

  task automatic bubble(input string name);
    step(0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0,
         1, 0, 5'd0, 32'h0, 0, 0, name);
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".wc"},  {63'd0, writeback_control}, {63'd0, e.wc});
        chk({e.name, ".mis"}, {63'd0, misaligned_load},   {63'd0, e.mis});
        chk({e.name, ".cnt"}, instret, e.cnt);
        if (e.ckdat) begin
          chk({e.name, ".rd"},   {59'd0, rd},          {59'd0, e.rd});
          chk({e.name, ".data"}, {32'd0, writeback_data}, {32'd0, e.data});
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    valid_m = 0; regwrite_m = 0; result_src_m = 0; funct3_m = 0; rd_m = 0;
    alu_result_m = 0; read_data_m = 0; pc_plus_4_m = 0; stall_w = 0; flush_w = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.wc",   {63'd0, writeback_control}, 64'd0);
    chk("rst.rd",   {59'd0, rd}, 64'd0);
    chk("rst.data", {32'd0, writeback_data}, 64'd0);
    chk("rst.cnt",  instret, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    //    v rw src    f3     rd     alu           rdata pc4    st fl  ck wc erd   edata         mis ret
    step(1, 1, 2'b00, 3'b000, 5'd5, 32'h1234,     32'h0, 32'h0, 0, 0, 1, 1, 5'd5, 32'h1234,     0, 1, "alu_rd5");
    bubble("after_alu");
    step(1, 1, 2'b01, 3'b000, 5'd7, 32'h1003,     W,     32'h0, 0, 0, 1, 1, 5'd7, 32'hFFFFFF80, 0, 1, "lb_off3");
    step(1, 1, 2'b01, 3'b100, 5'd8, 32'h1003,     W,     32'h0, 0, 0, 1, 1, 5'd8, 32'h00000080, 0, 1, "lbu_off3");
    step(1, 1, 2'b01, 3'b101, 5'd9, 32'h2002,     W,     32'h0, 0, 0, 1, 1, 5'd9, 32'h000080FF, 0, 1, "lhu_off2");
    step(1, 1, 2'b01, 3'b001, 5'd10, 32'h2001,    W,     32'h0, 0, 0, 1, 0, 5'd10, 32'h00007F01, 1, 0, "lh_off1_mis");
    step(1, 1, 2'b01, 3'b010, 5'd11, 32'h2002,    W,     32'h0, 0, 0, 1, 0, 5'd11, W,           1, 0, "lw_off2_mis");
    step(1, 1, 2'b01, 3'b001, 5'd12, 32'h2002,    W,     32'h0, 0, 0, 1, 1, 5'd12, 32'hFFFF80FF, 0, 1, "lh_off2");
    step(1, 1, 2'b01, 3'b000, 5'd14, 32'h3000,    W,     32'h0, 0, 0, 1, 1, 5'd14, 32'h00000001, 0, 1, "lb_off0");
    step(1, 1, 2'b01, 3'b000, 5'd15, 32'h3001,    W,     32'h0, 0, 0, 1, 1, 5'd15, 32'h0000007F, 0, 1, "lb_off1");
    step(1, 1, 2'b01, 3'b000, 5'd16, 32'h3002,    W,     32'h0, 0, 0, 1, 1, 5'd16, 32'hFFFFFFFF, 0, 1, "lb_off2");
    step(1, 1, 2'b01, 3'b100, 5'd17, 32'h3002,    W,     32'h0, 0, 0, 1, 1, 5'd17, 32'h000000FF, 0, 1, "lbu_off2");
    step(1, 1, 2'b01, 3'b010, 5'd18, 32'h3000,    W,     32'h0, 0, 0, 1, 1, 5'd18, W,           0, 1, "lw_off0");
    step(1, 1, 2'b10, 3'b000, 5'd0, 32'h55,       32'h0, 32'h200, 0, 0, 1, 0, 5'd0, 32'h200,     0, 1, "jal_rd0");
    step(1, 1, 2'b10, 3'b000, 5'd1, 32'h55,       32'h0, 32'h104, 0, 0, 1, 1, 5'd1, 32'h104,     0, 1, "jal_rd1");
    step(1, 1, 2'b11, 3'b000, 5'd3, 32'hDEADBEEF, 32'h0, 32'h104, 0, 0, 1, 1, 5'd3, 32'hDEADBEEF, 0, 1, "res_rsvd");
    step(1, 1, 2'b00, 3'b000, 5'd4, 32'hAAAA5555, 32'h0, 32'h0, 0, 0, 1, 1, 5'd4, 32'hAAAA5555, 0, 1, "alu_rd4");
    for (int unsigned i = 0; i < 3; i++)
      step(1, 1, 2'b00, 3'b000, 5'd6, 32'h1,      32'h0, 32'h0, 1, 0, 1, 1, 5'd4, 32'hAAAA5555, 0, 1, "stall");
    step(1, 1, 2'b00, 3'b000, 5'd6, 32'h1,        32'h0, 32'h0, 1, 1, 0, 0, 5'd0, 32'h0,        0, 0, "stall_flush");
    step(1, 1, 2'b00, 3'b000, 5'd6, 32'h66,       32'h0, 32'h0, 0, 0, 1, 1, 5'd6, 32'h66,       0, 1, "alu_rd6");
    step(1, 1, 2'b00, 3'b000, 5'd7, 32'h77,       32'h0, 32'h0, 0, 1, 0, 0, 5'd0, 32'h0,        0, 0, "flush");
    step(1, 0, 2'b00, 3'b000, 5'd9, 32'h50,       32'h0, 32'h0, 0, 0, 1, 0, 5'd9, 32'h50,       0, 1, "no_regwrite");
    bubble("drain1");
    step(1, 1, 2'b00, 3'b000, 5'd13, 32'h13,      32'h0, 32'h0, 0, 0, 1, 1, 5'd13, 32'h13,      0, 1, "pre_reset");

    // asynchronous reset mid-cycle with a valid instruction resident
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst.wc",   {63'd0, writeback_control}, 64'd0);
    chk("midrst.rd",   {59'd0, rd}, 64'd0);
    chk("midrst.data", {32'd0, writeback_data}, 64'd0);
    chk("midrst.mis",  {63'd0, misaligned_load}, 64'd0);
    chk("midrst.cnt",  instret, 64'd0);
    m_cnt = '0; m_pend = 1'b0;
    valid_m = 0; regwrite_m = 0; rd_m = 0; alu_result_m = 0;
    @(negedge clk);
    reset = 1'b1;
    bubble("post_reset");
    step(1, 1, 2'b00, 3'b000, 5'd2, 32'h22,       32'h0, 32'h0, 0, 0, 1, 1, 5'd2, 32'h22,       0, 1, "alu_rd2");
    bubble("drain2");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
